hazard_scoreboard: RTL and testbench

Parametrised hazard/stall unit for the five-stage MIPS pipeline, sitting beside the D stage. It holds a shift-register scoreboard of in-flight register writers with per-entry Tnew countdown and youngest-writer priority. It also provides an internal multi-cycle MDU busy counter and tracking of in-flight EPC writes. The result is a single registered-state stall decision for the instruction in D; pipeline registers and forwarding muxes stay outside.

---
 rtl/hazard_pkg.sv | 31 +++
 rtl/hazard_scoreboard_if.sv | 36 +++
 rtl/hazard_scoreboard_mdu_busy_counter.sv | 33 +++
 rtl/hazard_scoreboard.sv | 112 +++++++++++
 tb/tb_hazard_scoreboard.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared constants and types for the D-stage hazard/stall unit:
// Tnew/Tuse encodings, stall cause bit positions and the scoreboard entry layout.
package hazard_pkg;

  localparam logic [2:0] T_LOAD    = 3'd2;
  localparam logic [2:0] T_CALC    = 3'd1;
  localparam logic [2:0] T_NONE    = 3'd0;
  localparam logic [2:0] TUSE_NONE = 3'd7;

  localparam int unsigned WHY_RAW  = 0;
  localparam int unsigned WHY_MDU  = 1;
  localparam int unsigned WHY_ERET = 2;
  localparam int unsigned WHY_W    = 3;

  localparam int unsigned SB_AW = 5;
  localparam int unsigned SB_TW = 3;

  // Entry layout at the default register/Tnew geometry.
  typedef struct packed {
    logic             v;
    logic             we;
    logic [SB_AW-1:0] dst;
    logic [SB_TW-1:0] tnew;
    logic             epc;
  } sb_entry_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// D-stage request and stall-decision bundle between the pipeline and the hazard unit.
interface hazard_scoreboard_if #(
  parameter int unsigned NSRC = 2,
  parameter int unsigned AW   = 5,
  parameter int unsigned TW   = 3
);

  logic                 valid_D;
  logic [NSRC*AW-1:0]   src_D;
  logic [NSRC*TW-1:0]   tuse_D;
  logic [AW-1:0]        dst_D;
  logic                 we_D;
  logic [TW-1:0]        tnew_D;
  logic                 mdu_start_D;
  logic                 mdu_div_D;
  logic                 hilo_rd_D;
  logic                 mt_epc_D;
  logic                 eret_D;
  logic                 flush;
  logic                 stall;
  logic [2:0]           stall_why;
  logic                 mdu_busy;

  modport master (
    output valid_D, src_D, tuse_D, dst_D, we_D, tnew_D,
           mdu_start_D, mdu_div_D, hilo_rd_D, mt_epc_D, eret_D, flush,
    input  stall, stall_why, mdu_busy
  );

  modport slave (
    input  valid_D, src_D, tuse_D, dst_D, we_D, tnew_D,
           mdu_start_D, mdu_div_D, hilo_rd_D, mt_epc_D, eret_D, flush,
    output stall, stall_why, mdu_busy
  );

endinterface

// File: rtl/hazard_scoreboard_mdu_busy_counter.sv
// Multi-cycle MDU occupancy counter: loads the op latency on start, counts down to idle.
module mdu_busy_counter
  import hazard_pkg::*;
#(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic div,
  output logic busy
);

  localparam int unsigned CW = $clog2(max_u(MUL_LAT, DIV_LAT) + 1);
  localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT);
  localparam logic [CW-1:0] DIV_CNT = CW'(DIV_LAT);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= div ? DIV_CNT : MUL_CNT;
    end else if (count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// D-stage hazard unit: shift-register scoreboard of in-flight writers (E, M, W...),
// MDU busy tracking and pending-EPC tracking, reduced to one stall decision.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NSRC      = 2,
  parameter int unsigned AW        = 5,
  parameter int unsigned TW        = 3,
  parameter int unsigned DEPTH     = 3,
  parameter int unsigned EPC_DEPTH = 2,
  parameter int unsigned MUL_LAT   = 5,
  parameter int unsigned DIV_LAT   = 10
) (
  input  logic                clk,
  input  logic                reset_n,
  hazard_scoreboard_if.slave  hz
);

  typedef struct packed {
    logic          v;
    logic          we;
    logic [AW-1:0] dst;
    logic [TW-1:0] tnew;
    logic          epc;
  } entry_t;

  entry_t            sb [DEPTH];
  logic              accept;
  logic              raw;
  logic              eret_pend;
  logic              busy;
  logic              matched;
  logic [AW-1:0]     src;
  logic [TW-1:0]     tuse;
  logic [WHY_W-1:0]  why;

  // Scan from E outwards; the first matching writer is the youngest and alone decides.
  always_comb begin
    raw     = 1'b0;
    matched = 1'b0;
    src     = '0;
    tuse    = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      matched = 1'b0;
      src     = hz.src_D[i*AW +: AW];
      tuse    = hz.tuse_D[i*TW +: TW];
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (!matched && sb[k].v && sb[k].we && (sb[k].dst == src)) begin
          matched = 1'b1;
          if ((src != '0) && (tuse < sb[k].tnew)) begin
            raw = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    eret_pend = 1'b0;
    for (int unsigned k = 0; k < EPC_DEPTH; k++) begin
      if ((k < DEPTH) && sb[k].v && sb[k].epc) begin
        eret_pend = 1'b1;
      end
    end
  end

  always_comb begin
    why           = '0;
    why[WHY_RAW]  = raw;
    why[WHY_MDU]  = (hz.hilo_rd_D | hz.mdu_start_D) & busy;
    why[WHY_ERET] = hz.eret_D & eret_pend;
  end

  assign hz.stall     = hz.valid_D & (|why);
  assign hz.stall_why = why;
  assign hz.mdu_busy  = busy;
  assign accept       = hz.valid_D & ~hz.stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        sb[k] <= '0;
      end
    end else begin
      if (hz.flush || !accept) begin
        sb[0] <= '0;
      end else begin
        sb[0] <= '{v: 1'b1, we: hz.we_D, dst: hz.dst_D, tnew: hz.tnew_D, epc: hz.mt_epc_D};
      end
      for (int unsigned k = 1; k < DEPTH; k++) begin
        if (hz.flush) begin
          sb[k] <= '0;
        end else begin
          sb[k]      <= sb[k-1];
          sb[k].tnew <= (sb[k-1].tnew == '0) ? '0 : sb[k-1].tnew - TW'(1);
        end
      end
    end
  end

  mdu_busy_counter #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_mdu (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (accept & hz.mdu_start_D),
    .div     (hz.mdu_div_D),
    .busy    (busy)
  );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios with literal expectations,
// then randomized traffic checked every cycle against a cycle-stamped instruction history model.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam int NSRC      = 2;
  localparam int AW        = 5;
  localparam int TW        = 3;
  localparam int DEPTH     = 3;
  localparam int EPC_DEPTH = 2;
  localparam int MUL_LAT   = 5;
  localparam int DIV_LAT   = 10;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.NSRC(NSRC), .AW(AW), .TW(TW)) hz ();

  hazard_scoreboard #(
    .NSRC(NSRC), .AW(AW), .TW(TW), .DEPTH(DEPTH), .EPC_DEPTH(EPC_DEPTH),
    .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .hz      (hz)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Model: every accepted, unflushed instruction with the cycle it was accepted in.
  typedef struct {
    int cyc;
    bit we;
    int dst;
    int tnew;
    bit epc;
  } rec_t;

  rec_t recs[$];
  int   cyc      = 0;
  bit   mdu_seen = 1'b0;
  int   mdu_at   = 0;
  int   mdu_lat  = 0;

  function automatic bit model_busy();
    return mdu_seen && (cyc > mdu_at) && (cyc <= mdu_at + mdu_lat);
  endfunction

  function automatic logic [2:0] model_why();
    bit raw;
    bit epc_pend;
    int src;
    int tuse;
    int best;
    int k;
    int tn;
    raw = 1'b0;
    epc_pend = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      src  = int'(hz.src_D[i*AW +: AW]);
      tuse = int'(hz.tuse_D[i*TW +: TW]);
      best = -1;
      foreach (recs[j]) begin
        k = cyc - recs[j].cyc - 1;
        if (k >= 0 && k < DEPTH && recs[j].we && recs[j].dst == src) best = j;
      end
      if (src != 0 && best >= 0) begin
        k  = cyc - recs[best].cyc - 1;
        tn = recs[best].tnew - k;
        if (tn < 0) tn = 0;
        if (tuse < tn) raw = 1'b1;
      end
    end
    foreach (recs[j]) begin
      k = cyc - recs[j].cyc - 1;
      if (k >= 0 && k < EPC_DEPTH && recs[j].epc) epc_pend = 1'b1;
    end
    return {hz.eret_D && epc_pend, (hz.hilo_rd_D || hz.mdu_start_D) && model_busy(), raw};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    logic [2:0] w;
    bit acc;
    if (!reset_n) begin
      recs.delete();
      mdu_seen = 1'b0;
      cyc = 0;
    end else begin
      w   = model_why();
      acc = hz.valid_D && (w == 3'b000);
      if (acc && hz.mdu_start_D) begin
        mdu_seen = 1'b1;
        mdu_at   = cyc;
        mdu_lat  = hz.mdu_div_D ? DIV_LAT : MUL_LAT;
      end
      if (hz.flush) recs.delete();
      else if (acc) recs.push_back('{cyc, hz.we_D, int'(hz.dst_D), int'(hz.tnew_D), hz.mt_epc_D});
      while (recs.size() > 0 && cyc - recs[0].cyc >= DEPTH) void'(recs.pop_front());
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [2:0] e;
    if (chk_en) begin
      e = model_why();
      chk("model_stall", {2'b00, hz.stall}, {2'b00, hz.valid_D && (e != 3'b000)});
      chk("model_why", hz.stall_why, e);
      chk("model_busy", {2'b00, hz.mdu_busy}, {2'b00, model_busy()});
    end
  end

  task automatic idle();
    hz.valid_D = 1'b0; hz.src_D = '0; hz.tuse_D = {TUSE_NONE, TUSE_NONE};
    hz.dst_D = '0; hz.we_D = 1'b0; hz.tnew_D = T_NONE; hz.mdu_start_D = 1'b0;
    hz.mdu_div_D = 1'b0; hz.hilo_rd_D = 1'b0; hz.mt_epc_D = 1'b0; hz.eret_D = 1'b0;
    hz.flush = 1'b0;
  endtask

  task automatic instr(input bit we, input int dst, input int tnew,
                       input int s0, input int tu0, input int s1 = 0, input int tu1 = 7);
    idle();
    hz.valid_D = 1'b1; hz.we_D = we; hz.dst_D = AW'(dst); hz.tnew_D = TW'(tnew);
    hz.src_D = {AW'(s1), AW'(s0)}; hz.tuse_D = {TW'(tu1), TW'(tu0)};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input bit s, input logic [2:0] w, input bit b);
    #1;
    chk({name, "_stall"}, {2'b00, hz.stall}, {2'b00, s});
    chk({name, "_why"}, hz.stall_why, w);
    chk({name, "_busy"}, {2'b00, hz.mdu_busy}, {2'b00, b});
  endtask

  task automatic drain();
    idle();
    repeat (12) tick();
  endtask

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    lit("reset", 1'b0, 3'b000, 1'b0);
    reset_n = 1'b1;
    tick();

    // lw $8 then a Tuse-0 consumer: two stalled cycles
    instr(1, 8, T_LOAD, 0, TUSE_NONE);
    lit("t1_lw", 1'b0, 3'b000, 1'b0);
    tick();
    instr(1, 9, T_CALC, 8, 0);
    lit("t1_raw_a", 1'b1, 3'b001, 1'b0);
    tick();
    lit("t1_raw_b", 1'b1, 3'b001, 1'b0);
    tick();
    lit("t1_free", 1'b0, 3'b000, 1'b0);
    tick();

    // younger lw shadows older addu to the same register
    drain();
    instr(1, 8, T_CALC, 0, TUSE_NONE);
    tick();
    instr(1, 8, T_LOAD, 0, TUSE_NONE);
    lit("t2_lw", 1'b0, 3'b000, 1'b0);
    tick();
    instr(0, 0, T_NONE, 8, 0);
    lit("t2_raw_a", 1'b1, 3'b001, 1'b0);
    tick();
    lit("t2_raw_b", 1'b1, 3'b001, 1'b0);
    tick();
    lit("t2_free", 1'b0, 3'b000, 1'b0);
    tick();

    // $0 never creates a hazard
    drain();
    instr(1, 0, T_LOAD, 0, TUSE_NONE);
    tick();
    instr(1, 9, T_CALC, 0, 0, 0, 0);
    lit("t3_zero", 1'b0, 3'b000, 1'b0);
    tick();

    // mult busy window, with a div attempted mid-way
    drain();
    idle(); hz.valid_D = 1'b1; hz.mdu_start_D = 1'b1;
    lit("t4_mult", 1'b0, 3'b000, 1'b0);
    tick();
    for (int c = 1; c <= MUL_LAT; c++) begin
      idle(); hz.valid_D = 1'b1;
      if (c == 3) begin hz.mdu_start_D = 1'b1; hz.mdu_div_D = 1'b1; end
      else hz.hilo_rd_D = 1'b1;
      lit($sformatf("t4_c%0d", c), 1'b1, 3'b010, 1'b1);
      tick();
    end
    idle(); hz.valid_D = 1'b1; hz.hilo_rd_D = 1'b1;
    lit("t4_free", 1'b0, 3'b000, 1'b0);
    tick();

    // mtc0 EPC then eret; second round flushed mid-way
    drain();
    idle(); hz.valid_D = 1'b1; hz.mt_epc_D = 1'b1;
    tick();
    idle(); hz.valid_D = 1'b1; hz.eret_D = 1'b1;
    lit("t5_e1", 1'b1, 3'b100, 1'b0);
    tick();
    lit("t5_e2", 1'b1, 3'b100, 1'b0);
    tick();
    lit("t5_rel", 1'b0, 3'b000, 1'b0);
    tick();
    idle(); hz.valid_D = 1'b1; hz.mt_epc_D = 1'b1;
    tick();
    idle(); hz.valid_D = 1'b1; hz.eret_D = 1'b1; hz.flush = 1'b1;
    lit("t5_fl", 1'b1, 3'b100, 1'b0);
    tick();
    hz.flush = 1'b0;
    lit("t5_flclr", 1'b0, 3'b000, 1'b0);
    tick();

    // flush drops the simultaneously accepted lw
    drain();
    instr(1, 8, T_LOAD, 0, TUSE_NONE);
    hz.flush = 1'b1;
    tick();
    instr(1, 9, T_CALC, 8, 0);
    lit("t6_dep", 1'b0, 3'b000, 1'b0);
    tick();

    // async reset mid-operation
    drain();
    idle(); hz.valid_D = 1'b1; hz.mdu_start_D = 1'b1;
    tick();
    instr(1, 8, T_LOAD, 0, TUSE_NONE);
    tick();
    instr(1, 9, T_CALC, 8, 0);
    hz.hilo_rd_D = 1'b1;
    lit("t7_pre", 1'b1, 3'b011, 1'b1);
    reset_n = 1'b0;
    lit("t7_rst", 1'b0, 3'b000, 1'b0);
    reset_n = 1'b1;
    tick();

    // randomized traffic over a small register set
    for (int n = 0; n < 3000; n++) begin
      int r0, r1;
      idle();
      hz.valid_D     = ($urandom_range(0, 9) < 8);
      r0             = $urandom_range(0, 4);
      r1             = $urandom_range(0, 4);
      hz.src_D       = {AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3))};
      hz.tuse_D      = {TW'(r1 == 4 ? 7 : r1), TW'(r0 == 4 ? 7 : r0)};
      hz.dst_D       = AW'($urandom_range(0, 3));
      hz.we_D        = ($urandom_range(0, 3) != 0);
      hz.tnew_D      = TW'($urandom_range(0, 2));
      hz.mdu_start_D = ($urandom_range(0, 9) == 0);
      hz.mdu_div_D   = $urandom_range(0, 1) == 1;
      hz.hilo_rd_D   = ($urandom_range(0, 6) == 0);
      hz.mt_epc_D    = ($urandom_range(0, 9) == 0);
      hz.eret_D      = ($urandom_range(0, 6) == 0);
      hz.flush       = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 499) == 0) begin
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
      end
      tick();
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
